// File: rtl/bf_pkg.sv
// bf_pkg: shared state encodings and default datapath widths for the beamformer.
// Rev 1.0
`default_nettype none

package bf_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int OUT_W_DEF   = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bf_coord_gen.sv
// bf_coord_gen: line/depth index counters and incremental focal coordinate accumulators.
// Rev 1.0
`default_nettype none

module bf_coord_gen
  import bf_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int NUM_X   = 8,
  parameter int NUM_Z   = 32,
  parameter int X_START = 0,
  parameter int X_STEP  = 4,
  parameter int Z_START = 0,
  parameter int Z_STEP  = 16,
  localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1,
  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  output logic [XW-1:0]      x_idx,
  output logic [ZW-1:0]      z_idx,
  output logic [COORD_W-1:0] x_f,
  output logic [COORD_W-1:0] z_f,
  output logic               last
);

  localparam logic [XW-1:0]      X_LAST = XW'(NUM_X - 1);
  localparam logic [ZW-1:0]      Z_LAST = ZW'(NUM_Z - 1);
  localparam logic [COORD_W-1:0] X0     = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] Z0     = COORD_W'(Z_START);
  localparam logic [COORD_W-1:0] XS     = COORD_W'(X_STEP);
  localparam logic [COORD_W-1:0] ZS     = COORD_W'(Z_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_idx <= '0;
      z_idx <= '0;
      x_f   <= X0;
      z_f   <= Z0;
    end else if (load) begin
      x_idx <= '0;
      z_idx <= '0;
      x_f   <= X0;
      z_f   <= Z0;
    end else if (advance) begin
      // Depth runs fastest; a depth wrap steps to the next line.
      if (z_idx == Z_LAST) begin
        z_idx <= '0;
        z_f   <= Z0;
        x_idx <= x_idx + XW'(1);
        x_f   <= x_f + XS;
      end else begin
        z_idx <= z_idx + ZW'(1);
        z_f   <= z_f + ZS;
      end
    end
  end

  assign last = (x_idx == X_LAST) && (z_idx == Z_LAST);

endmodule

`default_nettype wire

// File: rtl/bf_scan_ctrl.sv
// bf_scan_ctrl: frame scan sequencer feeding focal points to the beamformer core.
// Rev 1.0
`default_nettype none

module bf_scan_ctrl
  import bf_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int NUM_X   = 8,
  parameter int NUM_Z   = 32,
  parameter int X_START = 0,
  parameter int X_STEP  = 4,
  parameter int Z_START = 0,
  parameter int Z_STEP  = 16,
  parameter int TIMEOUT = 255,
  localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1,
  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_start,
  input  logic               scan_abort,
  output logic               bf_start,
  output logic [COORD_W-1:0] bf_x_f,
  output logic [COORD_W-1:0] bf_z_f,
  input  logic               bf_valid,
  input  logic [OUT_W-1:0]   bf_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [XW-1:0]      out_x_idx,
  output logic [ZW-1:0]      out_z_idx,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [2:0]         state
);

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        st;
  logic [TW-1:0] tcnt;
  logic [XW-1:0] x_idx;
  logic [ZW-1:0] z_idx;
  logic          last;
  logic          load;
  logic          advance;

  assign load    = (st == ST_IDLE) && scan_start;
  assign advance = (st == ST_EMIT) && out_ready && !scan_abort && !last;

  bf_coord_gen #(
    .COORD_W (COORD_W),
    .NUM_X   (NUM_X),
    .NUM_Z   (NUM_Z),
    .X_START (X_START),
    .X_STEP  (X_STEP),
    .Z_START (Z_START),
    .Z_STEP  (Z_STEP)
  ) u_coord (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .x_idx   (x_idx),
    .z_idx   (z_idx),
    .x_f     (bf_x_f),
    .z_f     (bf_z_f),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= ST_IDLE;
      tcnt        <= '0;
      bf_start    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_x_idx   <= '0;
      out_z_idx   <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else if (scan_abort && (st != ST_IDLE)) begin
      // Abort drops everything in flight but keeps the sticky error visible.
      st        <= ST_IDLE;
      bf_start  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (scan_start) begin
            timeout_err <= 1'b0;
            bf_start    <= 1'b1;
            st          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bf_start <= 1'b0;
          tcnt     <= '0;
          st       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bf_valid) begin
            out_data  <= bf_data;
            out_x_idx <= x_idx;
            out_z_idx <= z_idx;
            out_last  <= last;
            out_valid <= 1'b1;
            st        <= ST_EMIT;
          end else if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            st          <= ST_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done <= 1'b1;
              st   <= ST_DONE;
            end else begin
              bf_start <= 1'b1;
              st       <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (st != ST_IDLE);
  assign state = st;

endmodule

`default_nettype wire

// File: tb/tb_bf_scan_ctrl.sv
// tb_bf_scan_ctrl: directed bench for bf_scan_ctrl with a fixed-latency core model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_bf_scan_ctrl;

  typedef struct {
    logic [15:0] x;
    logic [15:0] z;
    logic [17:0] data;
    logic        xi;
    logic [1:0]  zi;
    logic        last;
  } vec_t;

  typedef struct {
    logic [17:0] data;
    logic        xi;
    logic [1:0]  zi;
    logic        last;
  } samp_t;

  logic        clk = 1'b0;
  logic        reset, scan_start, scan_abort, out_ready;
  logic        bf_valid;
  logic [17:0] bf_data;
  logic        bf_start, out_valid, out_last, busy, done, timeout_err;
  logic [15:0] bf_x_f, bf_z_f;
  logic [17:0] out_data;
  logic [0:0]  out_x_idx;
  logic [1:0]  out_z_idx;
  logic [2:0]  state;

  int    n_cmp = 0, n_err = 0;
  int    n_start = 0, n_done = 0, n_acc = 0;
  int    suppress_pt = 0;
  logic  spur_req = 1'b0;
  samp_t samples[$];
  logic [31:0] coords[$];
  vec_t  vecs[6];

  always #5 clk = ~clk;

  bf_scan_ctrl #(
    .COORD_W (16),
    .OUT_W   (18),
    .NUM_X   (2),
    .NUM_Z   (3),
    .X_START (16'h0010),
    .X_STEP  (16'h0004),
    .Z_START (16'h0100),
    .Z_STEP  (16'h0020),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_start  (scan_start),
    .scan_abort  (scan_abort),
    .bf_start    (bf_start),
    .bf_x_f      (bf_x_f),
    .bf_z_f      (bf_z_f),
    .bf_valid    (bf_valid),
    .bf_data     (bf_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_x_idx   (out_x_idx),
    .out_z_idx   (out_z_idx),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // Core model: result {x_f[8:0], z_f[8:0]} four cycles after bf_start.
  initial begin : core_model
    int cd;
    int pt;
    logic [15:0] cx, cz;
    cd = -1; pt = 0; cx = '0; cz = '0;
    bf_valid = 1'b0;
    bf_data  = '0;
    forever begin
      @(negedge clk);
      bf_valid = 1'b0;
      if (!reset || !busy) begin
        cd = -1;
        pt = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bf_valid = 1'b1;
            bf_data  = {cx[8:0], cz[8:0]};
            cd = -1;
          end
        end
        if (spur_req && state == 3'd3) begin
          bf_valid = 1'b1;
          bf_data  = 18'h3ffff;
        end
        if (bf_start) begin
          pt++;
          if (pt != suppress_pt) begin
            cd = 4;
            cx = bf_x_f;
            cz = bf_z_f;
          end
        end
      end
    end
  end

  initial begin : monitor
    samp_t s;
    forever begin
      @(negedge clk);
      #2;
      if (bf_start) begin
        n_start++;
        coords.push_back({bf_x_f, bf_z_f});
      end
      if (done) n_done++;
      if (out_valid && out_ready) begin
        s.data = out_data; s.xi = out_x_idx; s.zi = out_z_idx; s.last = out_last;
        samples.push_back(s);
        n_acc++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start_frame();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_frame_end(input int base_done, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (n_done > base_done && !busy) hit = 1'b1;
      else tick();
    end
    chk("frame_end_in_budget", {31'd0, hit}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int sb, input int cb);
    samp_t s;
    chk($sformatf("%s_nsamp", tag), samples.size() - sb, 6);
    chk($sformatf("%s_ncoord", tag), coords.size() - cb, 6);
    for (int i = 0; i < 6; i++) begin
      if (sb + i < samples.size()) begin
        s = samples[sb + i];
        chk($sformatf("%s_data%0d", tag, i), {14'd0, s.data}, {14'd0, vecs[i].data});
        chk($sformatf("%s_xi%0d", tag, i), {31'd0, s.xi}, {31'd0, vecs[i].xi});
        chk($sformatf("%s_zi%0d", tag, i), {30'd0, s.zi}, {30'd0, vecs[i].zi});
        chk($sformatf("%s_last%0d", tag, i), {31'd0, s.last}, {31'd0, vecs[i].last});
      end
      if (cb + i < coords.size())
        chk($sformatf("%s_coord%0d", tag, i), coords[cb + i], {vecs[i].x, vecs[i].z});
    end
  endtask

  initial begin : main
    int sb, cb, db, sx, ab;
    logic found;
    logic [17:0] held;

    vecs[0] = '{16'h0010, 16'h0100, 18'h02100, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{16'h0010, 16'h0120, 18'h02120, 1'b0, 2'd1, 1'b0};
    vecs[2] = '{16'h0010, 16'h0140, 18'h02140, 1'b0, 2'd2, 1'b0};
    vecs[3] = '{16'h0014, 16'h0100, 18'h02900, 1'b1, 2'd0, 1'b0};
    vecs[4] = '{16'h0014, 16'h0120, 18'h02920, 1'b1, 2'd1, 1'b0};
    vecs[5] = '{16'h0014, 16'h0140, 18'h02940, 1'b1, 2'd2, 1'b1};

    reset = 1'b0; scan_start = 1'b0; scan_abort = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_bf_x_f", {16'd0, bf_x_f}, 32'h0010);
    chk("rst_bf_z_f", {16'd0, bf_z_f}, 32'h0100);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bf_start", {31'd0, bf_start}, 32'd0);
    chk("rst_out_data", {14'd0, out_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Full frame with out_ready held high
    sb = samples.size(); cb = coords.size(); db = n_done; sx = n_start;
    start_frame();
    chk("issue_bf_start", {31'd0, bf_start}, 32'd1);
    chk("issue_state", {29'd0, state}, 32'd1);
    wait_frame_end(db, 300);
    check_frame("full", sb, cb);
    chk("full_starts", n_start - sx, 6);
    chk("full_dones", n_done - db, 1);
    chk("full_idle", {29'd0, state}, 32'd0);

    // Backpressure on sample 2
    sb = samples.size(); cb = coords.size(); db = n_done; sx = n_start; ab = n_acc;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && (n_acc - ab == 1)) found = 1'b1;
      else tick();
    end
    chk("stall_reached", {31'd0, found}, 32'd1);
    held = out_data;
    chk("stall_data", {14'd0, held}, {14'd0, vecs[1].data});
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_valid%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall_hold%0d", k), {14'd0, out_data}, {14'd0, held});
      chk($sformatf("stall_nostart%0d", k), {31'd0, bf_start}, 32'd0);
    end
    out_ready = 1'b1;
    wait_frame_end(db, 300);
    check_frame("stall", sb, cb);
    chk("stall_starts", n_start - sx, 6);

    // Core never answers point 4
    suppress_pt = 4;
    sb = samples.size(); db = n_done; sx = n_start;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bf_start && (n_start - sx == 3)) found = 1'b1;
      else tick();
    end
    chk("to_reached", {31'd0, found}, 32'd1);
    repeat (16) tick();
    chk("to_err_pending", {31'd0, timeout_err}, 32'd0);
    chk("to_state_wait", {29'd0, state}, 32'd2);
    tick();
    chk("to_err_set", {31'd0, timeout_err}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_state_done", {29'd0, state}, 32'd4);
    tick();
    chk("to_idle", {29'd0, state}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_nsamp", samples.size() - sb, 3);
    chk("to_starts", n_start - sx, 4);
    suppress_pt = 0;
    sb = samples.size(); cb = coords.size(); db = n_done;
    start_frame();
    chk("to_err_cleared", {31'd0, timeout_err}, 32'd0);
    wait_frame_end(db, 300);
    check_frame("after_to", sb, cb);

    // Abort while sample 3 waits in EMIT
    db = n_done; ab = n_acc;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && (n_acc - ab == 2)) found = 1'b1;
      else tick();
    end
    chk("abort_reached", {31'd0, found}, 32'd1);
    scan_abort = 1'b1;
    out_ready  = 1'b0;
    tick();
    scan_abort = 1'b0;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("abort_no_done", n_done - db, 0);
    out_ready = 1'b1;
    sb = samples.size(); cb = coords.size(); db = n_done;
    start_frame();
    chk("restart_x", {16'd0, bf_x_f}, 32'h0010);
    chk("restart_z", {16'd0, bf_z_f}, 32'h0100);
    wait_frame_end(db, 300);
    check_frame("restart", sb, cb);

    // Mid-frame scan_start and a stray bf_valid during EMIT
    sb = samples.size(); cb = coords.size(); db = n_done; sx = n_start; ab = n_acc;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (state == 3'd2 && (n_start - sx == 2)) found = 1'b1;
      else tick();
    end
    chk("midstart_reached", {31'd0, found}, 32'd1);
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && (n_acc - ab == 3)) found = 1'b1;
      else tick();
    end
    chk("spur_reached", {31'd0, found}, 32'd1);
    out_ready = 1'b0;
    spur_req  = 1'b1;
    tick();
    spur_req  = 1'b0;
    tick();
    chk("spur_state", {29'd0, state}, 32'd3);
    chk("spur_data", {14'd0, out_data}, {14'd0, vecs[3].data});
    out_ready = 1'b1;
    wait_frame_end(db, 300);
    check_frame("ignored", sb, cb);
    chk("ignored_starts", n_start - sx, 6);
    chk("ignored_dones", n_done - db, 1);

    // Asynchronous reset while waiting for the core
    ab = n_acc;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (state == 3'd2 && (n_acc - ab == 1)) found = 1'b1;
      else tick();
    end
    chk("arst_reached", {31'd0, found}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out_data", {14'd0, out_data}, 32'd0);
    chk("arst_bf_x_f", {16'd0, bf_x_f}, 32'h0010);
    chk("arst_bf_z_f", {16'd0, bf_z_f}, 32'h0100);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_bf_start", {31'd0, bf_start}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
